apb4_mem_slave: RTL and testbench
=================================

Name: apb4_mem_slave

Overview:
- Parametrised APB4 completer backed by a register-array memory.
- Adds the following over the basic APB memory slave:
  - configurable data width, memory depth and fixed wait states;
  - PSTRB byte-lane writes;
  - PSLVERR on illegal accesses;
  - abort on protocol violation;
  - a saturating error counter.
- Sits on the peripheral bus behind the APB bridge as the generic scratch/config memory.

Parameters:
- DATA_WIDTH, 32, bus data width in bits; legal 8/16/32/64.
- ADDR_WIDTH, 32, PADDR width in bits.
- DEPTH, 64, number of DATA_WIDTH words; power of two, 2..1024.
- WAIT_STATES, 0, ACCESS-phase cycles with PREADY low before completion; 0..15.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error; meaningful only with PREADY.
- err_count  out  8  saturating count of errored or aborted transfers.

Behaviour:
- Reset and clocking:
  - One clock PCLK. PRESET is synchronous, active-high.
  - On reset: state=IDLE, wait counter=0, err_count=0, all memory words=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset mid-transfer abandons the transfer with no memory update.
- Constants:
  - BL = log2(DATA_WIDTH/8).
  - Word index = PADDR[BL+log2(DEPTH)-1 : BL].
- States: IDLE, ACCESS (the setup phase is sampled in IDLE).
- IDLE:
  - When PSEL=1 and PENABLE=0, capture PADDR, PWRITE, PWDATA and PSTRB.
  - Also capture err_flag, set when any of these holds:
    - PADDR >= DEPTH*(DATA_WIDTH/8);
    - PADDR[BL-1:0] != 0 (misaligned);
    - a read with PSTRB != 0.
  - Clear the counter and go to ACCESS.
  - PSEL=1 with PENABLE=1 in IDLE is ignored and stays in IDLE.
- ACCESS:
  - PREADY = (state==ACCESS) && PSEL && PENABLE && (cnt==WAIT_STATES). This is combinational from registered state.
  - While cnt<WAIT_STATES, cnt increments each cycle.
  - The completion cycle is the cycle with PREADY=1. Next state is IDLE.
  - Back-to-back transfers: the next setup phase arrives in the cycle after completion and is recognised in IDLE. Throughput is 2+WAIT_STATES cycles per transfer.
- Write completion without err_flag:
  - At the completion edge, byte lane i of mem[idx] takes PWDATA lane i where PSTRB[i]=1.
  - Other lanes are unchanged. PSTRB=0 is a legal no-op write.
- Read:
  - PRDATA = mem[idx] during the completion cycle if err_flag=0. Otherwise PRDATA=0.
  - A write completing in the same cycle is not visible until the next transfer.
- Error:
  - PSLVERR = PREADY && err_flag. Otherwise PSLVERR=0.
  - An errored write never modifies memory.
  - err_count increments at the completion edge of an errored transfer and saturates at 255.
- Protocol violation:
  - Applies in ACCESS when PSEL=0 or PENABLE=0, or when PADDR, PWRITE or PSTRB differ from the captured values.
  - Response: return to IDLE next cycle, drop the transfer (no write, no PREADY), increment err_count (saturating).
- Idle outputs: outside the completion cycle, PRDATA=0, PREADY=0, PSLVERR=0.
- Wait counter width is 4 bits; WAIT_STATES>15 is a parameter error.

Test Plan:
- Reset, then read 0x10 (DATA_WIDTH=32, WAIT_STATES=0) -> PREADY on 2nd bus cycle, PRDATA=0x00000000, PSLVERR=0.
- Write 0x10=0xDEADBEEF with PSTRB=4'b1111; write 0x10=0x11223344 with PSTRB=4'b0101; read 0x10 -> PRDATA=0xDE22BE44.
- WAIT_STATES=3: write then read 0x20 -> PREADY low exactly 3 ACCESS cycles, then high for 1; read data matches the written value.
- Read 0x100 (DEPTH=64, out of range) -> PSLVERR=1, PRDATA=0, err_count=1. Write 0x12 (misaligned) -> PSLVERR=1, memory unchanged, err_count=2.
- Drop PSEL mid-ACCESS with WAIT_STATES=2 -> no PREADY, memory unchanged, err_count increments, next transfer completes normally.
- Back-to-back writes to 0x0, 0x4, 0x8 with no idle cycle -> each completes in 2 cycles and all 3 values read back. Force 300 errored reads -> err_count=255. Assert PRESET mid-write -> err_count=0, memory cleared.

Source files
------------

// File: rtl/apb4_mem_slave.sv
// apb4_mem_slave: APB4 completer backed by a register-array memory.
//
// A transfer is recognised in IDLE on its setup phase (PSEL=1, PENABLE=0);
// address, direction, write data and strobes are captured together with an
// error flag. The block then sits in ACCESS for WAIT_STATES cycles with
// PREADY low, and completes in the following cycle. Any change of the
// control signals during ACCESS aborts the transfer.
//
// Ports:
//   PCLK       clock, rising edge
//   PRESET     synchronous active-high reset
//   PSEL       slave select
//   PENABLE    access-phase indicator
//   PWRITE     1 = write, 0 = read
//   PADDR      byte address
//   PWDATA     write data
//   PSTRB      write byte strobes
//   PRDATA     read data, non-zero only in an error-free read completion
//   PREADY     transfer completion
//   PSLVERR    transfer error, only together with PREADY
//   err_count  saturating count of errored or aborted transfers
module apb4_mem_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0   // 0..15, the wait counter is 4 bits
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [7:0]              err_count
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned BL     = $clog2(NBYTES);
    localparam int unsigned IW     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);
    // Low address bits that must be zero for a word-aligned access.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << BL) - 64'd1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [NBYTES-1:0]       strb_r;
    logic                    err_flag_r;
    logic [7:0]              err_count_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    setup_s;
    logic                    setup_err_s;
    logic                    match_s;
    logic                    pready_s;
    logic                    violation_s;
    logic [IW-1:0]           idx_s;

    // Saturating increment of the 8-bit error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    assign setup_s = PSEL && !PENABLE;
    assign idx_s   = addr_r[BL +: IW];

    // Any address bit above the memory window set means out of range.
    assign setup_err_s = ((PADDR >> (BL + IW)) != {ADDR_WIDTH{1'b0}})
                      || ((PADDR & ALIGN_MASK) != {ADDR_WIDTH{1'b0}})
                      || (!PWRITE && (PSTRB != {NBYTES{1'b0}}));

    // Access-phase checks: completion when stable and the wait count is used up.
    always_comb begin
        match_s     = PSEL && PENABLE && (PADDR == addr_r)
                   && (PWRITE == write_r) && (PSTRB == strb_r);
        pready_s    = 1'b0;
        violation_s = 1'b0;
        if (state_r == ACCESS) begin
            if (!match_s) begin
                violation_s = 1'b1;
            end else if (cnt_r == WAIT_LAST) begin
                pready_s = 1'b1;
            end else begin
                pready_s = 1'b0;
            end
        end else begin
            violation_s = 1'b0;
        end
    end

    assign PREADY    = pready_s;
    assign PSLVERR   = pready_s && err_flag_r;
    assign PRDATA    = (pready_s && !err_flag_r && !write_r) ? mem_r[idx_s]
                                                             : {DATA_WIDTH{1'b0}};
    assign err_count = err_count_r;

    // Transfer state machine, captured setup phase, memory and error counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            write_r     <= 1'b0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            strb_r      <= {NBYTES{1'b0}};
            err_flag_r  <= 1'b0;
            err_count_r <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // PSEL with PENABLE already high is not a setup phase.
                    if (setup_s) begin
                        addr_r     <= PADDR;
                        write_r    <= PWRITE;
                        wdata_r    <= PWDATA;
                        strb_r     <= PSTRB;
                        err_flag_r <= setup_err_s;
                        cnt_r      <= 4'd0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                ACCESS: begin
                    if (violation_s) begin
                        // Aborted: no memory update, counted as an error.
                        state_r     <= IDLE;
                        err_count_r <= sat_inc(err_count_r);
                    end else if (pready_s) begin
                        state_r <= IDLE;
                        if (err_flag_r) begin
                            err_count_r <= sat_inc(err_count_r);
                        end else if (write_r) begin
                            for (int i = 0; i < NBYTES; i++) begin
                                if (strb_r[i]) begin
                                    mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
                                end else begin
                                    mem_r[idx_s][8*i +: 8] <= mem_r[idx_s][8*i +: 8];
                                end
                            end
                        end else begin
                            err_count_r <= err_count_r;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Testbench for apb4_mem_slave: three instances with WAIT_STATES 0, 2 and 3
// share the bus signals except PSEL. A byte-addressed reference memory with
// an unbounded error tally predicts every response.
module tb_apb4_mem_slave;

    logic        clk = 1'b0;
    logic        preset;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];
    logic [7:0]  errcnt [3];

    int n_checks = 0;
    int n_errors = 0;
    int ws [3] = '{0, 2, 3};

    logic [7:0] mbytes [3][256];
    int         merr [3];

    always #5 clk = ~clk;

    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u0 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .err_count(errcnt[0]));
    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) u2 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .err_count(errcnt[1]));
    apb4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u3 (
        .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
        .PREADY(pready[2]), .PSLVERR(pslverr[2]), .err_count(errcnt[2]));

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic wr, input logic [31:0] a, input logic [3:0] st);
        return (a >= 32'd256) || ((a % 32'd4) != 32'd0) || (!wr && (st != 4'd0));
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = mbytes[d][a + i];
        return v;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st);
        for (int i = 0; i < 4; i++)
            if (st[i]) mbytes[d][a + i] = wd[8*i +: 8];
    endtask

    function automatic logic [7:0] model_cnt(input int d);
        return (merr[d] > 255) ? 8'd255 : 8'(merr[d]);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            merr[d] = 0;
            for (int i = 0; i < 256; i++) mbytes[d][i] = 8'h00;
        end
    endtask

    // ---------------- bus driving ----------------
    task automatic bus_idle();
        psel = 3'b000;
        penable = 1'b0;
    endtask

    // One APB transfer on instance d; returns after the completion edge (+1).
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic err,
                        output int waits);
        logic done;
        psel = 3'b000;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        pstrb = st;
        rd = 32'd0;
        err = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (pready[d]) begin
                rd = prdata[d];
                err = pslverr[d];
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 40) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pready_timeout: dut %0d addr 0x%0h", d, a);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        bus_idle();
    endtask

    // Transfer plus reference-model prediction and update.
    task automatic op(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int waits, output logic [31:0] exp_rd, output logic exp_err);
        exp_err = model_err(wr, a, st);
        exp_rd  = (!wr && !exp_err) ? model_read(d, a) : 32'd0;
        xfer(d, wr, a, wd, st, rd, err, waits);
        if (exp_err) merr[d]++;
        else if (wr) model_write(d, a, wd, st);
    endtask

    task automatic do_reset();
        bus_idle();
        preset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        preset = 1'b0;
        model_clear();
    endtask

    // Abort a write on instance 2 (WAIT_STATES=2) after one wait cycle.
    task automatic violate(input int kind);
        psel = 3'b010;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h30;
        pwdata = 32'h12345678;
        pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check($sformatf("viol%0d_pready_a", kind), 64'(pready[1]), 64'd0);
        @(posedge clk); #1;
        case (kind)
            0: psel = 3'b000;
            1: penable = 1'b0;
            2: paddr = 32'h34;
            3: pwrite = 1'b0;
            default: pstrb = 4'h3;
        endcase
        @(negedge clk);
        check($sformatf("viol%0d_pready_b", kind), 64'(pready[1]), 64'd0);
        @(posedge clk); #1;
        bus_idle();
        merr[1]++;
        check($sformatf("viol%0d_errcnt", kind), 64'(errcnt[1]), 64'(model_cnt(1)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          waits;

        // Directed vectors on the zero-wait instance.
        tbl[0]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'h00000000, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 8'd0};
        tbl[2]  = '{1'b1, 32'h10,  32'h11223344, 4'h5, 32'h0,        1'b0, 8'd0};
        tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h00000000, 1'b1, 8'd1};
        tbl[5]  = '{1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 8'd2};
        tbl[6]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, 8'd2};
        tbl[7]  = '{1'b0, 32'h10,  32'h0,        4'h1, 32'h00000000, 1'b1, 8'd3};
        tbl[8]  = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'h00000000, 1'b0, 8'd3};
        tbl[9]  = '{1'b1, 32'hFC,  32'hAABBCCDD, 4'h0, 32'h0,        1'b0, 8'd3};
        tbl[10] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'h00000000, 1'b0, 8'd3};
        tbl[11] = '{1'b1, 32'hFC,  32'hAABBCCDD, 4'hA, 32'h0,        1'b0, 8'd3};
        tbl[12] = '{1'b0, 32'hFC,  32'h0,        4'h0, 32'hAA00CC00, 1'b0, 8'd3};

        pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
        do_reset();

        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            check($sformatf("reset_pready%0d", d),  64'(pready[d]),  64'd0);
            check($sformatf("reset_pslverr%0d", d), 64'(pslverr[d]), 64'd0);
            check($sformatf("reset_prdata%0d", d),  64'(prdata[d]),  64'd0);
            check($sformatf("reset_errcnt%0d", d),  64'(errcnt[d]),  64'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            op(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, err, waits, exp_rd, exp_err);
            if (!tbl[i].wr) check($sformatf("tbl%0d_prdata", i), 64'(rd), 64'(tbl[i].exp_rdata));
            check($sformatf("tbl%0d_pslverr", i), 64'(err), 64'(tbl[i].exp_err));
            check($sformatf("tbl%0d_errcnt", i), 64'(errcnt[0]), 64'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_waits", i), 64'(waits), 64'd0);
        end

        // Three wait states: write then read 0x20, PREADY high for a single cycle.
        op(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, err, waits, exp_rd, exp_err);
        check("ws3_write_waits", 64'(waits), 64'd3);
        @(negedge clk);
        check("ws3_pready_drop", 64'(pready[2]), 64'd0);
        @(posedge clk); #1;
        op(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
        check("ws3_read_waits", 64'(waits), 64'd3);
        check("ws3_read_data", 64'(rd), 64'hCAFEF00D);

        // Protocol violations on the two-wait instance.
        for (int k = 0; k < 5; k++) begin
            violate(k);
            op(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
            check($sformatf("viol%0d_mem", k), 64'(rd), 64'd0);
            check($sformatf("viol%0d_next_waits", k), 64'(waits), 64'd2);
            check($sformatf("viol%0d_next_err", k), 64'(err), 64'd0);
        end

        // Back-to-back writes: no idle cycle between transfers.
        for (int i = 0; i < 3; i++) begin
            op(0, 1'b1, 32'(i * 4), 32'hA5A50000 + 32'(i), 4'hF, rd, err, waits, exp_rd, exp_err);
            check($sformatf("b2b_waits%0d", i), 64'(waits), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            op(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
            check($sformatf("b2b_read%0d", i), 64'(rd), 64'hA5A50000 + 64'(i));
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 250; n++) begin
            int          d;
            logic        wr;
            logic [31:0] a;
            logic [3:0]  st;
            d  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'h100 + ($urandom_range(0, 63) << 2);
                1:       a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
                default: a = $urandom_range(0, 15) << 2;
            endcase
            st = wr ? 4'($urandom_range(0, 15))
                    : (($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
            op(d, wr, a, $urandom, st, rd, err, waits, exp_rd, exp_err);
            check("rand_pslverr", 64'(err), 64'(exp_err));
            if (!wr) check("rand_prdata", 64'(rd), 64'(exp_rd));
            check("rand_waits", 64'(waits), 64'(ws[d]));
            check("rand_errcnt", 64'(errcnt[d]), 64'(model_cnt(d)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Drive the error counter into saturation.
        for (int n = 0; n < 300; n++) begin
            op(0, 1'b0, 32'h100, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
        end
        check("sat_errcnt", 64'(errcnt[0]), 64'd255);
        check("sat_pslverr", 64'(err), 64'd1);
        check("sat_prdata", 64'(rd), 64'd0);

        // Reset in the middle of a waited write.
        op(0, 1'b1, 32'h10, 32'h55667788, 4'hF, rd, err, waits, exp_rd, exp_err);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h24; pwdata = 32'h87654321; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        bus_idle();
        model_clear();
        for (int d = 0; d < 3; d++)
            check($sformatf("midrst_errcnt%0d", d), 64'(errcnt[d]), 64'd0);
        op(2, 1'b0, 32'h24, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
        check("midrst_mem24", 64'(rd), 64'd0);
        op(2, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
        check("midrst_mem20", 64'(rd), 64'd0);
        op(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, waits, exp_rd, exp_err);
        check("midrst_mem10", 64'(rd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
